// File: rtl/traffic_pkg.sv
// traffic_pkg
// Shared types and constants for the intersection phase sequencer:
//   phase_t     - 3-bit phase code driven onto the phase output
//   RED/YEL/GRN - one-hot lamp encodings, bit order {red, yellow, green}
//   dur_t       - 8-bit timer duration
//   lamps_t     - lamp bundle for one phase (ns, ew, walk)
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5,
    WALK = 3'd6
  } phase_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  typedef logic [7:0] dur_t;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // A zero count would never produce a done edge from the timer, so it is
  // forced to 1; anything wider than the duration field saturates.
  function automatic dur_t clamp_dur(int unsigned t);
    if (t == 0)        return dur_t'(1);
    else if (t > 255)  return dur_t'(255);
    else               return dur_t'(t);
  endfunction

  // Lamp pattern for each phase. Every pattern is one-hot per direction,
  // so registering it straight from the next phase gives no overlap cycle.
  function automatic lamps_t lamps_for(phase_t p);
    lamps_t l;
    l = '{ns: RED, ew: RED, walk: 1'b0};
    case (p)
      NS_G:    l.ns   = GRN;
      NS_Y:    l.ns   = YEL;
      EW_G:    l.ew   = GRN;
      EW_Y:    l.ew   = YEL;
      WALK:    l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl
// Two-way intersection phase sequencer. Steps NS green/yellow, all-red,
// EW green/yellow, all-red, and inserts a pedestrian WALK phase after an
// all-red when a request is pending. It drives the request side of a shared
// down-count timer and advances on the rising edge of the timer's done flag.
//
// Ports:
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   enable         in   1 = run, 0 = freeze timer and phase
//   ped_req        in   pedestrian button (level)
//   timer_done     in   done flag from the timer
//   timer_start    out  timer run request (registered)
//   timer_duration out  count for the current phase (registered)
//   ns_light       out  one-hot {red, yellow, green}, north-south
//   ew_light       out  one-hot {red, yellow, green}, east-west
//   walk           out  pedestrian walk lamp
//   phase          out  current phase code
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN  = 20,
  parameter int unsigned T_YELLOW = 4,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_WALK   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       timer_done,
  output logic       timer_start,
  output logic [7:0] timer_duration,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam dur_t DUR_GREEN  = clamp_dur(T_GREEN);
  localparam dur_t DUR_YELLOW = clamp_dur(T_YELLOW);
  localparam dur_t DUR_ALLRED = clamp_dur(T_ALLRED);
  localparam dur_t DUR_WALK   = clamp_dur(T_WALK);

  function automatic dur_t dur_for(phase_t p);
    case (p)
      NS_G, EW_G: return DUR_GREEN;
      NS_Y, EW_Y: return DUR_YELLOW;
      WALK:       return DUR_WALK;
      default:    return DUR_ALLRED;
    endcase
  endfunction

  // State
  phase_t phase_q,       phase_d;
  lamps_t lamps_q,       lamps_d;
  dur_t   dur_q,         dur_d;
  logic   start_q,       start_d;
  logic   done_q;
  logic   ped_pending_q, ped_pending_d;
  logic   ret_ew_q,      ret_ew_d;   // 1: WALK returns to EW_G, 0: to NS_G

  logic   phase_end;
  logic   enter_walk;

  // Only the rising edge of done ends a phase: the timer keeps done high
  // through the gap cycle until it reloads, and that level must not count.
  assign phase_end = timer_done & ~done_q;

  // NOTE: the state register uses non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop regardless of
  // statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= AR_B;
      lamps_q       <= lamps_for(AR_B);
      dur_q         <= DUR_ALLRED;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      ped_pending_q <= 1'b0;
      ret_ew_q      <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      lamps_q       <= lamps_d;
      dur_q         <= dur_d;
      start_q       <= start_d;
      done_q        <= timer_done;
      ped_pending_q <= ped_pending_d;
      ret_ew_q      <= ret_ew_d;
    end
  end

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    phase_d  = phase_q;
    ret_ew_d = ret_ew_q;
    // Run whenever enabled; dropping start freezes the timer count.
    start_d  = enable;

    if (phase_end) begin
      // Hold start low for the entry cycle so the timer sees a gap and
      // reloads with the new phase's duration rather than the old one.
      start_d = 1'b0;
      case (phase_q)
        NS_G: phase_d = NS_Y;
        NS_Y: phase_d = AR_A;
        AR_A: begin
          if (ped_pending_q) begin
            phase_d  = WALK;
            ret_ew_d = 1'b1;
          end else begin
            phase_d  = EW_G;
          end
        end
        EW_G: phase_d = EW_Y;
        EW_Y: phase_d = AR_B;
        AR_B: begin
          if (ped_pending_q) begin
            phase_d  = WALK;
            ret_ew_d = 1'b0;
          end else begin
            phase_d  = NS_G;
          end
        end
        WALK:    phase_d = ret_ew_q ? EW_G : NS_G;
        default: phase_d = AR_B;
      endcase
    end

    enter_walk = phase_end && (phase_d == WALK);

    // A press on the same cycle as WALK entry survives and requests
    // another walk after the next all-red.
    ped_pending_d = ped_req | (ped_pending_q & ~enter_walk);

    lamps_d = lamps_for(phase_d);
    dur_d   = dur_for(phase_d);
  end

  assign timer_start    = start_q;
  assign timer_duration = dur_q;
  assign ns_light       = lamps_q.ns;
  assign ew_light       = lamps_q.ew;
  assign walk           = lamps_q.walk;
  assign phase          = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl
// Scoreboard bench for traffic_phase_ctrl with a behavioural down-count
// timer beside it. The stimulus process pushes the expected sequence of
// phase entries (phase code plus length and start-low cycles of the phase
// just left); the monitor pops one record on every phase change it sees.
module tb_traffic_phase_ctrl;

  localparam int P_NSG  = 0;
  localparam int P_NSY  = 1;
  localparam int P_ARA  = 2;
  localparam int P_EWG  = 3;
  localparam int P_EWY  = 4;
  localparam int P_ARB  = 5;
  localparam int P_WALK = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       ped_req;
  logic       timer_done;
  logic       timer_start;
  logic [7:0] timer_duration;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic [2:0] phase;

  traffic_phase_ctrl #(
    .T_GREEN (5),
    .T_YELLOW(2),
    .T_ALLRED(1),
    .T_WALK  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .ped_req       (ped_req),
    .timer_done    (timer_done),
    .timer_start   (timer_start),
    .timer_duration(timer_duration),
    .ns_light      (ns_light),
    .ew_light      (ew_light),
    .walk          (walk),
    .phase         (phase)
  );

  always #5 clk = ~clk;

  // Timer model: loads on an edge with start=1 and count 0 once start has
  // been low for a cycle, decrements on edges with start=1, raises done as
  // the count goes 1->0 and keeps it until the next load.
  logic [7:0] t_cnt;
  logic       t_armed;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt      <= 8'd0;
      timer_done <= 1'b0;
      t_armed    <= 1'b0;
    end else begin
      t_armed <= ~timer_start;
      if (timer_start) begin
        if (t_cnt == 8'd0) begin
          if (t_armed) begin
            t_cnt      <= timer_duration;
            timer_done <= 1'b0;
          end
        end else begin
          t_cnt <= t_cnt - 8'd1;
          if (t_cnt == 8'd1) timer_done <= 1'b1;
        end
      end
    end
  end

  // Scoreboard
  typedef struct {
    int ph;     // phase just entered
    int len;    // cycles spent in the phase just left
    int gaps;   // cycles with timer_start low in the phase just left
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int actual, int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int exp_ns(int ph);
    if (ph == P_NSG) return 1;
    if (ph == P_NSY) return 2;
    return 4;
  endfunction

  function automatic int exp_ew(int ph);
    if (ph == P_EWG) return 1;
    if (ph == P_EWY) return 2;
    return 4;
  endfunction

  function automatic int exp_dur(int ph);
    if (ph == P_NSG || ph == P_EWG) return 5;
    if (ph == P_NSY || ph == P_EWY) return 2;
    if (ph == P_WALK)               return 3;
    return 1;
  endfunction

  task automatic push(int ph, int len, int gaps);
    exp_t e;
    e.ph   = ph;
    e.len  = len;
    e.gaps = gaps;
    q.push_back(e);
  endtask

  // Waits until the monitor has consumed every expected entry.
  task automatic drain(string name, int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, q.size(), 0);
    q.delete();
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_phase"}, int'(phase), P_ARB);
    check({tag, "_ns"}, int'(ns_light), 4);
    check({tag, "_ew"}, int'(ew_light), 4);
    check({tag, "_walk"}, int'(walk), 0);
    check({tag, "_start"}, int'(timer_start), 0);
    check({tag, "_dur"}, int'(timer_duration), 1);
  endtask

  // Monitor
  int mon_prev = P_ARB;
  int mon_len  = 0;
  int mon_gaps = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = int'(phase);
        mon_len  = 0;
        mon_gaps = 0;
      end else begin
        if (!$onehot(ns_light) || !$onehot(ew_light)) begin
          n_checks++;
          $display("FAIL lamp_onehot: ns=%b ew=%b", ns_light, ew_light);
        end
        if (int'(phase) != mon_prev) begin
          if (q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_phase: got %0d after %0d, expected no change",
                     phase, mon_prev);
          end else begin
            e = q.pop_front();
            check("phase", int'(phase), e.ph);
            check("ns_light", int'(ns_light), exp_ns(e.ph));
            check("ew_light", int'(ew_light), exp_ew(e.ph));
            check("walk", int'(walk), (e.ph == P_WALK) ? 1 : 0);
            check("duration", int'(timer_duration), exp_dur(e.ph));
            check("prev_len", mon_len, e.len);
            check("prev_gaps", mon_gaps, e.gaps);
          end
          mon_prev = int'(phase);
          mon_len  = 1;
          mon_gaps = (timer_start == 1'b0) ? 1 : 0;
        end else begin
          mon_len++;
          if (timer_start == 1'b0) mon_gaps++;
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst     = 1'b1;
    enable  = 1'b1;
    ped_req = 1'b0;

    // Reset, then free run for one full period.
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    push(P_NSG, 4, 1);
    push(P_NSY, 8, 1);
    push(P_ARA, 5, 1);
    push(P_EWG, 4, 1);
    push(P_EWY, 8, 1);
    push(P_ARB, 5, 1);
    push(P_NSG, 4, 1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("edge3_phase", int'(phase), P_ARB);
    @(posedge clk);
    #1;
    check("edge4_phase", int'(phase), P_NSG);
    check("edge4_ns", int'(ns_light), 1);
    drain("free_run_drained", 200);

    // One-cycle pedestrian pulse at the start of NS_G.
    push(P_NSY, 8, 1);
    push(P_ARA, 5, 1);
    push(P_WALK, 4, 1);
    push(P_EWG, 6, 1);
    push(P_EWY, 8, 1);
    push(P_ARB, 5, 1);
    push(P_NSG, 4, 1);
    ped_req = 1'b1;
    @(posedge clk);
    #1;
    ped_req = 1'b0;
    drain("ped_pulse_drained", 200);

    // Pause for ten cycles in the middle of EW_G.
    push(P_NSY, 8, 1);
    push(P_ARA, 5, 1);
    push(P_EWG, 4, 1);
    drain("to_ewg_drained", 200);
    repeat (3) @(negedge clk);
    #1;
    enable = 1'b0;
    push(P_EWY, 18, 11);
    push(P_ARB, 5, 1);
    push(P_NSG, 4, 1);
    repeat (5) @(negedge clk);
    #1;
    check("pause_start", int'(timer_start), 0);
    check("pause_phase", int'(phase), P_EWG);
    check("pause_ew", int'(ew_light), 1);
    repeat (5) @(negedge clk);
    #1;
    enable = 1'b1;
    drain("pause_drained", 200);

    // Pedestrian button held: WALK after every all-red.
    ped_req = 1'b1;
    push(P_NSY, 8, 1);
    push(P_ARA, 5, 1);
    push(P_WALK, 4, 1);
    push(P_EWG, 6, 1);
    push(P_EWY, 8, 1);
    push(P_ARB, 5, 1);
    push(P_WALK, 4, 1);
    push(P_NSG, 6, 1);
    drain("ped_held_drained", 200);
    ped_req = 1'b0;

    // Asynchronous reset in the middle of NS_Y.
    push(P_NSY, 8, 1);
    drain("to_nsy_drained", 200);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    push(P_NSG, 4, 1);
    push(P_NSY, 8, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst2_edge3_phase", int'(phase), P_ARB);
    @(posedge clk);
    #1;
    check("rst2_edge4_phase", int'(phase), P_NSG);
    drain("restart_drained", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Intersection phase sequencer that drives the shared down-count timer's request side (start, duration) and consumes its done flag. It steps a two-way intersection through green/yellow/all-red phases and inserts a pedestrian walk phase on request. Lamp outputs go straight to the board pins. The timer is instantiated beside this block in the intersection top level, on the same clock and reset.

## Interface
- T_GREEN, 20: green phase count, 1..255
- T_YELLOW, 4: yellow phase count, 1..255
- T_ALLRED, 2: all-red phase count, 1..255
- T_WALK, 10: walk phase count, 1..255
- Value 0 for any count is clamped to 1 at elaboration.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  1 = run; 0 = freeze the timer and phase
- ped_req  in  1  pedestrian button, level, sampled every cycle
- timer_done  in  1  done flag from the timer
- timer_start  out  1  timer run request, registered
- timer_duration  out  8  count for the current phase, registered
- ns_light  out  3  one-hot {red, yellow, green}
- ew_light  out  3  one-hot {red, yellow, green}
- walk  out  1  pedestrian walk lamp
- phase  out  3  current phase code

## Operation
- Phase codes:
  - 0 NS_G (ns green, ew red)
  - 1 NS_Y (ns yellow, ew red)
  - 2 AR_A (both red)
  - 3 EW_G
  - 4 EW_Y
  - 5 AR_B (both red)
  - 6 WALK (both red, walk=1)
- Sequence: NS_G→NS_Y→AR_A→EW_G→EW_Y→AR_B→NS_G.
- From AR_A or AR_B with ped_pending=1, go to WALK instead of the next green. WALK then goes to the green that would have followed (EW_G after AR_A, NS_G after AR_B). A 1-bit return flag holds that choice.
- Durations by phase: greens use T_GREEN, yellows T_YELLOW, all-reds T_ALLRED, WALK T_WALK.
- Timer protocol:
  - The timer loads duration on an edge where start=1 and its count is 0.
  - It decrements on each edge with start=1.
  - It raises done on the edge where the count goes 1→0.
  - done stays 1 until the next load.
- Phase entry (edge P):
  - Lights, phase and timer_duration update.
  - timer_start←0 for exactly one cycle, so the timer cannot reload the old duration.
  - At P+1, timer_start←1 if enable=1.
- Phase end event = timer_done & ~done_q, where done_q is timer_done registered. Only this rising edge advances the phase. A done level held through the gap cycle is ignored.
- enable=0: timer_start←0 on the next edge, which freezes the timer count. Lights and phase hold. A done rising edge that still arrives (from the in-flight edge) is honoured and advances the phase. Restoring enable=1 resumes the count where it stopped.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge that enters WALK, unless ped_req=1 on that same cycle (set wins).

## Timing
- Phase length with enable held high = T+3 cycles: 1 gap, 1 load, T counts, 1 edge-detect.
- Reset values:
  - phase=5 (AR_B)
  - ns_light=ew_light=3'b100
  - walk=0
  - timer_start=0
  - timer_duration=T_ALLRED
  - done_q=0, ped_pending=0, return flag=0
- Reset release acts as entry edge P of AR_B, so the first NS_G is entered T_ALLRED+3 cycles after release.
- Reset mid-phase returns all outputs to their reset values immediately (asynchronous). The timer resets with it.
- Light outputs are always exactly one-hot, with no overlap cycle between phases.

## Structure
- Shared package traffic_pkg holds:
  - the phase enum (3 bits, codes above)
  - lamp one-hot constants RED/YEL/GRN
  - an 8-bit duration type
- Single FSM module, no sub-module.
- Timer pairing lives in intersection_top.

## Test plan
All scenarios use T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=3, with the real timer instanced.
- Reset, hold enable=1: all outputs at reset values. phase=0 and ns_light=001 on the 4th edge after release.
- Free run, no ped_req: phase durations NS_G 8, NS_Y 5, AR_A 4, EW_G 8, EW_Y 5, AR_B 4; period 34 cycles. timer_start is low exactly one cycle per phase.
- 1-cycle ped_req pulse during NS_G: AR_A→WALK (walk=1 for 6 cycles)→EW_G. ped_pending clears. The next AR_B goes to NS_G.
- enable=0 for 10 cycles mid EW_G: timer_start=0 during the pause and the lights hold. EW_G lasts 18 cycles.
- ped_req held high: WALK is inserted after every all-red phase. Period 46 cycles.
- rst pulse mid NS_Y: outputs return to reset values in the same cycle. The sequence restarts with AR_B→NS_G after 4 cycles.
